// File: rtl/hash_mm_bridge.sv
// Avalon-MM slave bridging a host CPU to a streaming hash core: lane-staged
// input FIFO toward the core, shift-in digest capture, status/IRQ registers.
module hash_mm_bridge #(
  parameter int CORE_W      = 64,
  parameter int DIGEST_BITS = 256,
  parameter int FIFO_DEPTH  = 4,
  parameter int BYTE_SWAP   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        address,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  input  logic              write,
  input  logic              read,
  input  logic              chipselect,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic              core_rst,
  output logic              core_src_ready,
  input  logic              core_src_read,
  output logic [CORE_W-1:0] core_din,
  output logic              core_dst_ready,
  input  logic              core_dst_write,
  input  logic [CORE_W-1:0] core_dout
);

  localparam int LANES  = CORE_W / 32;
  localparam int DWORDS = DIGEST_BITS / 32;
  localparam int NWORDS = DIGEST_BITS / CORE_W;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int LW     = PW + 1;
  localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  logic [CORE_W-1:0]      r_stage;
  logic [CORE_W-1:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]          r_wptr, r_rptr;
  logic [LW-1:0]          r_level;
  logic [DIGEST_BITS-1:0] r_digest;
  logic [CW-1:0]          r_cnt;
  logic                   r_digestValid, r_overflow, r_hold, r_irqEn, r_softPulse;

  logic [CORE_W-1:0]      w_stageNext, w_word;
  logic [DIGEST_BITS-1:0] w_digestShift;
  logic [31:0]            w_beMask, w_rdData;
  logic w_wr, w_push, w_pushOk, w_pop, w_overflow, w_capture, w_last;
  logic w_ctrlWr, w_softRst, w_statusWr, w_full, w_empty;

  assign w_wr       = write & chipselect;
  assign w_beMask   = {{8{byteenable[3]}}, {8{byteenable[2]}}, {8{byteenable[1]}}, {8{byteenable[0]}}};
  assign w_ctrlWr   = w_wr && (address == 6'h30) && byteenable[0];
  assign w_softRst  = w_ctrlWr && writedata[0];
  assign w_statusWr = w_wr && (address == 6'h31) && byteenable[0];

  // Lane merge; the write to the top lane also pushes the assembled word.
  always_comb begin
    w_stageNext = r_stage;
    w_push      = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      if (w_wr && (address == 6'(32 + k))) begin
        w_stageNext[32*k +: 32] = (r_stage[32*k +: 32] & ~w_beMask) | (writedata & w_beMask);
        if (k == LANES - 1) w_push = 1'b1;
      end
    end
  end

  assign w_empty    = (r_level == '0);
  assign w_full     = (r_level == LW'(FIFO_DEPTH));
  assign w_pop      = core_src_read && !w_empty;
  assign w_pushOk   = w_push && (!w_full || core_src_read);
  assign w_overflow = w_push && !w_pushOk;

  assign core_din       = r_mem[r_rptr];
  assign core_src_ready = w_empty;
  assign core_dst_ready = r_hold & r_digestValid;
  assign core_rst       = reset | r_softPulse;

  always_ff @(posedge clk) begin
    if (reset || w_softRst) begin
      r_stage <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      r_stage <= w_stageNext;
      if (w_pushOk) r_wptr <= r_wptr + 1'b1;
      if (w_pop)    r_rptr <= r_rptr + 1'b1;
      if (w_pushOk && !w_pop)      r_level <= r_level + 1'b1;
      else if (!w_pushOk && w_pop) r_level <= r_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_pushOk) r_mem[r_wptr] <= w_stageNext;
  end

  generate
    if (BYTE_SWAP != 0) begin : g_swap
      for (genvar i = 0; i < CORE_W / 8; i++) begin : g_byte
        assign w_word[8*i +: 8] = core_dout[CORE_W-8-8*i +: 8];
      end
    end else begin : g_noswap
      assign w_word = core_dout;
    end
    if (NWORDS > 1) begin : g_shift
      assign w_digestShift = {w_word, r_digest[DIGEST_BITS-1:CORE_W]};
    end else begin : g_single
      assign w_digestShift = w_word;
    end
  endgenerate

  assign w_capture = core_dst_write && !core_dst_ready;
  assign w_last    = (r_cnt == CW'(NWORDS - 1));

  // Digest survives a soft reset; only the word position restarts.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_digest <= '0;
      r_cnt    <= '0;
    end else if (w_softRst) begin
      r_cnt <= '0;
    end else if (w_capture) begin
      r_digest <= w_digestShift;
      r_cnt    <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_digestValid <= 1'b0;
      r_overflow    <= 1'b0;
      r_hold        <= 1'b0;
      r_irqEn       <= 1'b0;
      r_softPulse   <= 1'b0;
      irq           <= 1'b0;
    end else begin
      r_softPulse <= w_softRst;
      irq         <= r_irqEn & r_digestValid;
      if (w_ctrlWr) begin
        r_hold  <= writedata[1];
        r_irqEn <= writedata[2];
      end
      if (w_softRst) begin
        r_digestValid <= 1'b0;
        r_overflow    <= 1'b0;
      end else begin
        if (w_capture && w_last)                r_digestValid <= 1'b1;
        else if (w_capture && r_cnt == '0)      r_digestValid <= 1'b0;
        else if (w_statusWr && writedata[0])    r_digestValid <= 1'b0;
        if (w_overflow)                         r_overflow <= 1'b1;
        else if (w_statusWr && writedata[1])    r_overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rdData = '0;
    for (int k = 0; k < DWORDS; k++) begin
      if (address == 6'(k)) w_rdData = r_digest[32*k +: 32];
    end
    for (int k = 0; k < LANES; k++) begin
      if (address == 6'(32 + k)) w_rdData = r_stage[32*k +: 32];
    end
    if (address == 6'h30) w_rdData = {29'b0, r_irqEn, r_hold, 1'b0};
    if (address == 6'h31) w_rdData = {16'b0, 8'(r_level), 4'b0, w_full, w_empty, r_overflow, r_digestValid};
  end

  always_ff @(posedge clk) begin
    if (reset)                    readdata <= '0;
    else if (read && chipselect)  readdata <= w_rdData;
  end

endmodule

// File: tb/tb_hash_mm_bridge.sv
// Directed self-checking bench for hash_mm_bridge (default parameters:
// 64-bit core words, 256-bit digest, 4-deep FIFO, byte swap on).
module tb_hash_mm_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  address;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        write, read, chipselect;
  logic [31:0] readdata;
  logic        irq, core_rst, core_src_ready, core_src_read;
  logic [63:0] core_din;
  logic        core_dst_ready, core_dst_write;
  logic [63:0] core_dout;

  int vecCount  = 0;
  int missCount = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  hash_mm_bridge #(.CORE_W(64), .DIGEST_BITS(256), .FIFO_DEPTH(4), .BYTE_SWAP(1)) dut (
    .clk(clk), .reset(reset), .address(address), .writedata(writedata),
    .byteenable(byteenable), .write(write), .read(read), .chipselect(chipselect),
    .readdata(readdata), .irq(irq), .core_rst(core_rst),
    .core_src_ready(core_src_ready), .core_src_read(core_src_read), .core_din(core_din),
    .core_dst_ready(core_dst_ready), .core_dst_write(core_dst_write), .core_dout(core_dout)
  );

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bus tasks start and end on a falling edge; one rising edge sees the strobe.
  task automatic busWrite(input logic [5:0] a, input logic [31:0] d);
    address = a; writedata = d; byteenable = 4'hF; chipselect = 1'b1; write = 1'b1;
    @(negedge clk);
    write = 1'b0; chipselect = 1'b0;
  endtask

  task automatic busRead(input logic [5:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read = 1'b1;
    @(negedge clk);
    read = 1'b0; chipselect = 1'b0;
    d = readdata;
  endtask

  task automatic pushWord(input logic [63:0] w, input logic popToo);
    busWrite(6'h20, w[31:0]);
    core_src_read = popToo;
    busWrite(6'h21, w[63:32]);
    core_src_read = 1'b0;
  endtask

  task automatic popWord();
    core_src_read = 1'b1;
    @(negedge clk);
    core_src_read = 1'b0;
  endtask

  task automatic applyStimulus(input logic [63:0] w);
    core_dst_write = 1'b1; core_dout = w;
    @(negedge clk);
    core_dst_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; address = '0; writedata = '0; byteenable = '0;
    write = 1'b0; read = 1'b0; chipselect = 1'b0;
    core_src_read = 1'b0; core_dst_write = 1'b0; core_dout = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_core_rst", core_rst, 1);
    checkOutput("rst_readdata", readdata, 0);
    checkOutput("rst_irq", irq, 0);
    checkOutput("rst_src_ready", core_src_ready, 1);
    checkOutput("rst_dst_ready", core_dst_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("core_rst_low", core_rst, 0);
    busRead(6'h31, rd);
    checkOutput("status_reset", rd, 32'h4);

    // Single push then pop
    pushWord(64'h5566778811223344, 1'b0);
    checkOutput("push1_din", core_din, 64'h5566778811223344);
    checkOutput("push1_src_ready", core_src_ready, 0);
    busRead(6'h31, rd);
    checkOutput("push1_status", rd, 32'h100);
    popWord();
    checkOutput("pop1_src_ready", core_src_ready, 1);

    // Overflow on the fifth push, then push+pop at full
    for (int i = 1; i <= 5; i++) pushWord({32'hA0 + 32'(i), 32'(i)}, 1'b0);
    busRead(6'h31, rd);
    checkOutput("full_status", rd, 32'h40A);
    checkOutput("full_head", core_din, {32'hA1, 32'h1});
    busWrite(6'h31, 32'h2);
    busRead(6'h31, rd);
    checkOutput("ovf_w1c_status", rd, 32'h408);
    pushWord({32'hA6, 32'h6}, 1'b1);
    busRead(6'h31, rd);
    checkOutput("pushpop_status", rd, 32'h408);
    checkOutput("fifo_order0", core_din, {32'hA2, 32'h2}); popWord();
    checkOutput("fifo_order1", core_din, {32'hA3, 32'h3}); popWord();
    checkOutput("fifo_order2", core_din, {32'hA4, 32'h4}); popWord();
    checkOutput("fifo_order3", core_din, {32'hA6, 32'h6}); popWord();
    checkOutput("drained_src_ready", core_src_ready, 1);

    // Digest capture with byte swap and IRQ
    busWrite(6'h30, 32'h4);
    for (int i = 0; i < 4; i++) applyStimulus(64'h0102030405060708 + 64'(i));
    checkOutput("irq_not_yet", irq, 0);
    @(negedge clk);
    checkOutput("irq_set", irq, 1);
    busRead(6'h00, rd); checkOutput("digest_w0", rd, 32'h04030201);
    busRead(6'h01, rd); checkOutput("digest_w1", rd, 32'h08070605);
    busRead(6'h03, rd); checkOutput("digest_w3", rd, 32'h09070605);
    busRead(6'h07, rd); checkOutput("digest_w7", rd, 32'h0B070605);
    busRead(6'h31, rd); checkOutput("digest_status", rd, 32'h5);
    busRead(6'h3F, rd); checkOutput("unmapped_read", rd, 32'h0);

    // Backpressure hold
    busWrite(6'h30, 32'h6);
    checkOutput("hold_dst_ready", core_dst_ready, 1);
    applyStimulus(64'hDEADBEEFCAFEF00D);
    busRead(6'h00, rd); checkOutput("hold_digest_w0", rd, 32'h04030201);
    busWrite(6'h31, 32'h1);
    checkOutput("w1c_dst_ready", core_dst_ready, 0);
    checkOutput("irq_lag", irq, 1);
    @(negedge clk);
    checkOutput("irq_cleared", irq, 0);

    // Soft reset mid-digest
    busWrite(6'h30, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(64'h5555AAAA00000000 + 64'(i));
    pushWord(64'h0123456789ABCDEF, 1'b0);
    busWrite(6'h30, 32'h5);
    checkOutput("soft_core_rst_hi", core_rst, 1);
    @(negedge clk);
    checkOutput("soft_core_rst_lo", core_rst, 0);
    busRead(6'h31, rd); checkOutput("soft_status", rd, 32'h4);
    busRead(6'h30, rd); checkOutput("soft_ctrl", rd, 32'h4);
    for (int i = 0; i < 3; i++) applyStimulus(64'h1122334455667788 + 64'(i));
    busRead(6'h31, rd); checkOutput("fresh_partial_status", rd, 32'h4);
    applyStimulus(64'h112233445566778B);
    busRead(6'h31, rd); checkOutput("fresh_status", rd, 32'h5);
    busRead(6'h00, rd); checkOutput("fresh_w0", rd, 32'h44332211);
    busRead(6'h07, rd); checkOutput("fresh_w7", rd, 32'h8B776655);
    checkOutput("fresh_irq", irq, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
